// File: rtl/sum_serializer_pkg.sv
// Shared types and constants for the sum serializer: FSM state encoding and
// the default serial bit period.
package sum_serializer_pkg;

  localparam int CLK_DIV_DEFAULT = 4;
  localparam int FRAME_BITS      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sum_serializer_if.sv
// Control, data and serial-output bundle of the sum serializer, with the
// upstream side (master) and the serializer side (slave) as modports.
interface sum_serializer_if;
  import sum_serializer_pkg::*;

  // Handshake: a frame is requested by a rising edge of start seen on an
  // enabled cycle while idle; busy covers the shifting phase, and done pulses
  // once, for one enabled cycle, when the frame ends.
  // Edges seen while busy or done are dropped, never queued.
  logic       ena;
  logic [7:0] data_in;
  logic       start;
  logic       ser_out;
  logic       ser_clk;
  logic       busy;
  logic       done;
  state_e     state_dbg;

  modport master (
    output ena, data_in, start,
    input  ser_out, ser_clk, busy, done, state_dbg
  );

  modport slave (
    input  ena, data_in, start,
    output ser_out, ser_clk, busy, done, state_dbg
  );

endinterface

// File: rtl/ser_bit_timer.sv
// Bit-period divider: counts CLK_DIV enabled cycles per serial bit, generates
// the ser_clk strobe (high in the second half) and the end-of-bit tick.
module ser_bit_timer
  import sum_serializer_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena_i,
  input  logic clr_i,
  input  logic run_i,
  output logic ser_clk_o,
  output logic bit_tick_o
);

  localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  localparam logic [W-1:0] HALF = W'(CLK_DIV / 2);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;

  always_comb begin
    div_d = div_q;
    if (clr_i) begin
      div_d = '0;
    end else if (run_i) begin
      div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (ena_i) begin
      div_q <= div_d;
    end
  end

  // Both outputs are gated by run_i so they stay low outside of shifting.
  assign bit_tick_o = run_i && (div_q == LAST);
  assign ser_clk_o  = run_i && (div_q >= HALF);

endmodule

// File: rtl/sum_serializer.sv
// Serializes an 8-bit sum word MSB first on a launch edge of start, with a
// divided bit strobe, busy during shifting and a one-cycle done at frame end.
module sum_serializer
  import sum_serializer_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  sum_serializer_if.slave  bus
);

  state_e     state_q;
  state_e     state_d;
  logic       start_q;
  logic [7:0] sr_q;
  logic [7:0] sr_d;
  logic [2:0] bit_q;
  logic [2:0] bit_d;
  logic       launch;
  logic       timer_clr;
  logic       bit_tick;
  logic       timer_clk;
  logic       shifting;

  assign launch   = bus.start && !start_q;
  assign shifting = (state_q == SHIFT);

  ser_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena_i      (bus.ena),
    .clr_i      (timer_clr),
    .run_i      (shifting),
    .ser_clk_o  (timer_clk),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_d     = bit_q;
    timer_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (launch) begin
          sr_d      = bus.data_in;
          bit_d     = 3'd0;
          timer_clr = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // The last bit ends the frame without a further shift.
        if (bit_tick) begin
          if (bit_q == 3'd7) begin
            state_d = DONE;
          end else begin
            sr_d  = {sr_q[6:0], 1'b0};
            bit_d = bit_q + 3'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      sr_q    <= 8'd0;
      bit_q   <= 3'd0;
    end else if (bus.ena) begin
      state_q <= state_d;
      start_q <= bus.start;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
    end
  end

  assign bus.busy      = shifting;
  assign bus.done      = (state_q == DONE);
  assign bus.ser_out   = shifting && sr_q[7];
  assign bus.ser_clk   = timer_clk;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sum_serializer.sv
// Bench for sum_serializer: directed frames plus random data and enable
// patterns, checked by a frame monitor against a queue of expected words.
module tb_sum_serializer;
  import sum_serializer_pkg::*;

  localparam int DIV       = 4;
  localparam int FRAME_CYC = 8 * DIV;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [7:0] exp_q[$];

  sum_serializer_if bus ();

  sum_serializer #(.CLK_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Reference: in the k-th enabled shifting cycle (k from 0) of a frame
  // carrying word w, ser_out = w[7 - k/DIV] and ser_clk = (k mod DIV) >= DIV/2;
  // the frame spans FRAME_CYC enabled cycles followed by done.
  logic [7:0] cur_exp = 8'd0;
  int         k = 0;
  bit         in_frame = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", {28'd0, bus.ser_out, bus.ser_clk, bus.busy, bus.done}, 32'd0);
      in_frame = 1'b0;
    end else begin
      if (!in_frame && bus.busy) begin
        if (exp_q.size() == 0) begin
          check("spurious_frame", 32'd1, 32'd0);
          cur_exp = 8'd0;
        end else begin
          cur_exp = exp_q.pop_front();
        end
        in_frame = 1'b1;
        k = 0;
      end
      if (in_frame) begin
        if (bus.busy) begin
          if (k >= FRAME_CYC) begin
            check("frame_overrun", k, FRAME_CYC - 1);
          end else begin
            check("ser_out", {31'd0, bus.ser_out}, {31'd0, cur_exp[7 - k / DIV]});
            check("ser_clk", {31'd0, bus.ser_clk}, {31'd0, ((k % DIV) >= DIV / 2)});
          end
          check("done_in_shift", {31'd0, bus.done}, 32'd0);
          if (bus.ena) k++;
        end else begin
          check("frame_end_done", {31'd0, bus.done}, 32'd1);
          check("frame_len", k, FRAME_CYC);
          if (bus.ena || !bus.done) in_frame = 1'b0;
        end
      end else begin
        check("idle_outputs", {29'd0, bus.ser_out, bus.ser_clk, bus.done}, 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for the end of a launched frame. Cycle count starts at 1 on the
  // edge that samples the launch. start is dropped once busy is seen (hold=0)
  // or at cycle hold; a one-cycle extra edge can be placed at reedge_at.
  task automatic await_frame(input int exp_lat, input int stall_at, input int stall_len,
                             input int reedge_at, input int hold, input bit rnd_ena);
    int         cyc = 0;
    bit         got = 1'b0;
    logic [3:0] snap = 4'd0;
    while (!got && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rnd_ena) bus.ena = ($urandom_range(0, 3) != 0);
      if (hold == 0 && bus.busy) bus.start = 1'b0;
      else if (hold > 0 && cyc == hold) bus.start = 1'b0;
      if (cyc == reedge_at) bus.start = 1'b1;
      if (cyc == reedge_at + 1) bus.start = 1'b0;
      if (stall_len > 0) begin
        if (cyc == stall_at) begin
          bus.ena = 1'b0;
          snap = {bus.ser_out, bus.ser_clk, bus.busy, bus.done};
        end else if (cyc > stall_at && cyc <= stall_at + stall_len) begin
          check("stall_freeze", {28'd0, bus.ser_out, bus.ser_clk, bus.busy, bus.done}, {28'd0, snap});
        end
        if (cyc == stall_at + stall_len) bus.ena = 1'b1;
      end
      if (bus.done) got = 1'b1;
    end
    check("frame_seen", {31'd0, got}, 32'd1);
    if (!rnd_ena && got) check("latency", cyc, exp_lat);
    bus.ena = 1'b1;
    while (cyc < hold) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic run_frame(input logic [7:0] d, input int stall_at, input int stall_len,
                           input int reedge_at, input int hold, input bit rnd_ena);
    @(posedge clk);
    #1;
    bus.data_in = d;
    bus.start   = 1'b1;
    exp_q.push_back(d);
    await_frame(FRAME_CYC + 1 + stall_len, stall_at, stall_len, reedge_at, hold, rnd_ena);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    bus.ena     = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {30'd0, bus.state_dbg}, {30'd0, IDLE});
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame, both extremes, then a held start and an ignored re-edge.
    run_frame(8'hA5, 0, 0, -10, 0, 1'b0);
    run_frame(8'h00, 0, 0, -10, 0, 1'b0);
    run_frame(8'hFF, 0, 0, -10, 0, 1'b0);
    run_frame(8'h5A, 0, 0, -10, 100, 1'b0);
    repeat (40) @(posedge clk);
    run_frame(8'hC3, 0, 0, 10, 0, 1'b0);
    repeat (40) @(posedge clk);

    // Five-cycle stall in the middle of bit 3.
    run_frame(8'h96, 14, 5, -10, 0, 1'b0);

    // Reset in the middle of a frame with start still high at release.
    @(posedge clk);
    #1;
    bus.data_in = 8'hAA;
    bus.start   = 1'b1;
    exp_q.push_back(8'hAA);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    bus.data_in = 8'h3C;
    rst_n = 1'b0;
    #1;
    check("reset_async", {28'd0, bus.ser_out, bus.ser_clk, bus.busy, bus.done}, 32'd0);
    check("reset_async_state", {30'd0, bus.state_dbg}, {30'd0, IDLE});
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(8'h3C);
    rst_n = 1'b1;
    await_frame(FRAME_CYC + 1, 0, 0, -10, 0, 1'b0);

    // Random words with random enable gaps.
    for (int i = 0; i < 16; i++) begin
      run_frame(8'($urandom_range(0, 255)), 0, 0, -10, 0, 1'b1);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum_serializer.md
SUM_SERIALIZER -- requirements
Module: sum_serializer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per serial bit; even, >= 2.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 SHALL have port ena, input, 1: advance enable; low freezes all state.
REQ-005 SHALL have port data_in, input, 8: unsigned sum word from the upstream ui_in + uio_in adder stage.
REQ-006 SHALL have port start, input, 1: launch request, rising-edge sensitive.
REQ-007 SHALL have port ser_out, output, 1: serial data, MSB first.
REQ-008 SHALL have port ser_clk, output, 1: bit strobe; receivers sample on its rising edge.
REQ-009 SHALL have port busy, output, 1: high while a frame is shifting.
REQ-010 SHALL have port done, output, 1: one-cycle pulse at frame end.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-012 SHALL register start every enabled cycle; a launch edge is start=1 with previous sample 0.
REQ-013 SHALL, in IDLE on a launch edge: capture data_in into an 8-bit shift register, clear the divider and bit counters, and enter SHIFT.
REQ-014 SHALL drive bit 7 of the captured word on ser_out from the cycle after capture (latency 1).
REQ-015 SHALL hold each bit for exactly CLK_DIV enabled cycles; divider counter width is clog2(CLK_DIV).
REQ-016 SHALL drive ser_clk low for divider counts 0..CLK_DIV/2-1 and high for CLK_DIV/2..CLK_DIV-1 of each bit.
REQ-017 SHALL, at divider count CLK_DIV-1, shift the register left by one and increment the 3-bit bit counter.
REQ-018 SHALL, when the bit counter is 7 and the divider count is CLK_DIV-1, enter DONE instead of shifting.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE.
REQ-020 SHALL assert busy exactly while in SHIFT.
REQ-021 SHALL drive ser_out and ser_clk to 0 in IDLE and DONE.
REQ-022 SHALL ignore launch edges occurring in SHIFT or DONE; they are neither queued nor stored.
REQ-023 SHALL produce exactly one frame when start is held high; a new frame requires start to return low and rise again after IDLE is reached.
REQ-024 SHALL, with ena low, hold state, counters, shift register, edge sample and all outputs (done stretches while frozen in DONE).
REQ-025 SHALL make a frame last exactly 8*CLK_DIV enabled cycles in SHIFT plus 1 cycle in DONE.

Reset
REQ-026 SHALL, on rst_n low, immediately and asynchronously set state IDLE, all counters and the shift register to 0, the start sample to 0, and all outputs to 0.
REQ-027 SHALL abort a frame in progress on reset, with no done pulse; after reset release the first launch edge starts a fresh frame.
REQ-028 SHALL treat start already high at reset release as an edge (sample resets to 0).

Structure
REQ-029 SHALL place the FSM state enum and the CLK_DIV default constant in shared package sum_serializer_pkg.
REQ-030 SHALL use one sub-module, ser_bit_timer, containing the divider counter and ser_clk/bit-tick generation; edge detection, FSM and shift register live in sum_serializer.

Verification
REQ-031 SHALL verify basic frame: CLK_DIV=4, data_in=0xA5, start rises at cycle 0 -> ser_out = 1,0,1,0,0,1,0,1, each held 4 cycles from cycle 1; ser_clk high on the 3rd and 4th cycle of each bit; done=1 at cycle 33 only; busy high for cycles 1..32.
REQ-032 SHALL verify extremes: data_in 0x00 and 0xFF -> ser_out constant 0 and 1 respectively for 32 cycles; ser_clk toggles identically in both.
REQ-033 SHALL verify launch handling: start held high for 100 cycles -> one frame only; a second edge at cycle 10 of a frame -> ignored, no second frame.
REQ-034 SHALL verify stall: ena low for 5 cycles mid-bit-3 -> all outputs frozen; done arrives at cycle 38.
REQ-035 SHALL verify reset abort: rst_n low at cycle 15 of a frame -> outputs 0 the same cycle; no done; a new edge after release yields a correct full frame of new data_in=0x3C.
